// File: rtl/spi_pkg.sv
// Shared types for the SPI transaction scheduler.
// States and field widths used by the scheduler and its arbiter.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        BUSY,
        READ,
        DONE
    } sched_state_t;

    typedef logic [1:0] spi_mode_t;

    localparam int SPI_BYTE_SEL_W = 3;

endpackage

// File: rtl/spi_txn_scheduler_rr_arbiter.sv
// Round-robin arbiter: first request at or after ptr, wrapping.
// Purely combinational one-hot grant.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic [IW:0] pos;
    logic        found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 0; k < N; k++) begin
            pos = {1'b0, ptr} + (IW+1)'(k);
            if (pos >= (IW+1)'(N)) pos = pos - (IW+1)'(N);
            if (!found && req[pos[IW-1:0]]) begin
                gnt[pos[IW-1:0]] = 1'b1;
                found            = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_txn_scheduler.sv
// Shares one spi_controller between several requesters with
// round-robin grant, timeout abort and read-back of result data.
module spi_txn_scheduler
    import spi_pkg::*;
#(
    parameter int REQ_CNT        = 4,
    parameter int DATA_WIDTH     = 64,
    parameter int PERI_CNT       = 4,
    parameter int TIMEOUT_CYCLES = 4096,
    localparam int PW = (PERI_CNT > 1) ? $clog2(PERI_CNT) : 1,
    localparam int IW = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1,
    localparam int BW = SPI_BYTE_SEL_W
) (
    input  logic                          clk,
    input  logic                          sync_rst_n,
    input  logic                          clk_en,
    input  logic [REQ_CNT-1:0]            req_valid,
    output logic [REQ_CNT-1:0]            req_ready,
    input  logic [REQ_CNT*PW-1:0]         req_peri,
    input  logic [REQ_CNT*2-1:0]          req_mode,
    input  logic [REQ_CNT*BW-1:0]         req_bytes,
    input  logic [REQ_CNT*DATA_WIDTH-1:0] req_wdata,
    output logic [REQ_CNT-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_timeout,
    output logic                          spi_wr_en,
    output logic                          spi_start_txn,
    output spi_mode_t                     spi_mode,
    output logic [BW-1:0]                 spi_byte_sel,
    output logic [DATA_WIDTH-1:0]         spi_wr_data,
    output logic [PERI_CNT-1:0]           spi_chip_sel_one_cold,
    output logic                          spi_rd_en,
    input  logic [DATA_WIDTH-1:0]         spi_rd_data,
    input  logic                          spi_end_txn
);

    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    sched_state_t          state;
    sched_state_t          state_nxt;
    logic [IW-1:0]         ptr_q;
    logic [IW-1:0]         g_q;
    logic [REQ_CNT-1:0]    gnt;
    logic [REQ_CNT-1:0]    ready_q;
    logic [IW-1:0]         sel_idx;
    logic [PW-1:0]         sel_peri;
    spi_mode_t             sel_mode;
    logic [BW-1:0]         sel_bytes;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [PW-1:0]         peri_q;
    spi_mode_t             mode_q;
    logic [BW-1:0]         bytes_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  to_q;
    logic [CW-1:0]         cnt_q;

    rr_arbiter #(.N(REQ_CNT)) u_arb (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (gnt)
    );

    always_comb begin
        sel_idx   = '0;
        sel_peri  = '0;
        sel_mode  = '0;
        sel_bytes = '0;
        sel_wdata = '0;
        for (int i = 0; i < REQ_CNT; i++) begin
            if (gnt[i]) begin
                sel_idx   = IW'(i);
                sel_peri  = req_peri[i*PW +: PW];
                sel_mode  = req_mode[i*2 +: 2];
                sel_bytes = req_bytes[i*BW +: BW];
                sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge sync_rst_n) begin
        if (!sync_rst_n) state <= IDLE;
        else if (clk_en) state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req_valid) state_nxt = LOAD;
            LOAD:    state_nxt = START;
            START:   state_nxt = BUSY;
            BUSY: begin
                if (spi_end_txn)            state_nxt = READ;
                else if (cnt_q == CNT_LAST) state_nxt = DONE;
            end
            READ:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge sync_rst_n) begin
        if (!sync_rst_n) begin
            ready_q <= '0;
            ptr_q   <= '0;
            g_q     <= '0;
            peri_q  <= '0;
            mode_q  <= '0;
            bytes_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            to_q    <= 1'b0;
            cnt_q   <= '0;
        end else if (clk_en) begin
            ready_q <= '0;
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        ready_q <= gnt;
                        g_q     <= sel_idx;
                        peri_q  <= sel_peri;
                        mode_q  <= sel_mode;
                        bytes_q <= sel_bytes;
                        wdata_q <= sel_wdata;
                        rdata_q <= '0;
                        to_q    <= 1'b0;
                    end
                end
                START: cnt_q <= '0;
                // end beats a timeout expiring in the same cycle
                BUSY: begin
                    if (!spi_end_txn) begin
                        if (cnt_q == CNT_LAST) to_q <= 1'b1;
                        else cnt_q <= cnt_q + 1'b1;
                    end
                end
                READ: rdata_q <= spi_rd_data;
                DONE: begin
                    ptr_q <= (g_q == IW'(REQ_CNT - 1)) ? '0 : g_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        spi_chip_sel_one_cold = '1;
        if (state != IDLE && {1'b0, peri_q} < (PW+1)'(PERI_CNT))
            spi_chip_sel_one_cold[peri_q] = 1'b0;
    end

    assign req_ready     = ready_q;
    assign rsp_valid     = (state == DONE) ? (REQ_CNT'(1) << g_q) : '0;
    assign rsp_rdata     = rdata_q;
    assign rsp_timeout   = (state == DONE) & to_q;
    assign spi_wr_en     = (state == LOAD);
    assign spi_start_txn = (state == START);
    assign spi_rd_en     = (state == READ);
    assign spi_mode      = mode_q;
    assign spi_byte_sel  = bytes_q;
    assign spi_wr_data   = wdata_q;

endmodule

// File: tb/tb_spi_txn_scheduler.sv
// Directed bench for spi_txn_scheduler with a small controller model.
`timescale 1ns/1ps
module tb_spi_txn_scheduler;

    logic         clk = 1'b0;
    logic         sync_rst_n;
    logic         clk_en;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [7:0]   req_peri;
    logic [7:0]   req_mode;
    logic [11:0]  req_bytes;
    logic [255:0] req_wdata;
    logic [3:0]   rsp_valid;
    logic [63:0]  rsp_rdata;
    logic         rsp_timeout;
    logic         spi_wr_en;
    logic         spi_start_txn;
    logic [1:0]   spi_mode;
    logic [2:0]   spi_byte_sel;
    logic [63:0]  spi_wr_data;
    logic [3:0]   spi_chip_sel_one_cold;
    logic         spi_rd_en;
    logic [63:0]  spi_rd_data;
    logic         spi_end_txn;

    int n_tests = 0;
    int n_fail  = 0;
    int en_mode = 0;
    int m_delay = 10;
    bit m_run   = 0;
    int m_cnt   = 0;
    int n_wr, n_start, n_rd, n_rsp, n_ready;

    spi_txn_scheduler #(.TIMEOUT_CYCLES(16)) dut (
        .clk                   (clk),
        .sync_rst_n            (sync_rst_n),
        .clk_en                (clk_en),
        .req_valid             (req_valid),
        .req_ready             (req_ready),
        .req_peri              (req_peri),
        .req_mode              (req_mode),
        .req_bytes             (req_bytes),
        .req_wdata             (req_wdata),
        .rsp_valid             (rsp_valid),
        .rsp_rdata             (rsp_rdata),
        .rsp_timeout           (rsp_timeout),
        .spi_wr_en             (spi_wr_en),
        .spi_start_txn         (spi_start_txn),
        .spi_mode              (spi_mode),
        .spi_byte_sel          (spi_byte_sel),
        .spi_wr_data           (spi_wr_data),
        .spi_chip_sel_one_cold (spi_chip_sel_one_cold),
        .spi_rd_en             (spi_rd_en),
        .spi_rd_data           (spi_rd_data),
        .spi_end_txn           (spi_end_txn)
    );

    always #5 clk = ~clk;

    initial begin
        clk_en = 1'b1;
        forever begin
            @(negedge clk);
            case (en_mode)
                0:       clk_en = 1'b1;
                1:       clk_en = ~clk_en;
                default: clk_en = 1'b0;
            endcase
        end
    end

    // controller model: end pulse m_delay enabled cycles after start
    initial begin
        bit s_en, s_start;
        spi_end_txn = 1'b0;
        forever begin
            @(posedge clk);
            s_en    = clk_en;
            s_start = spi_start_txn;
            #1;
            if (s_en) begin
                if (s_start) begin
                    m_run = 1;
                    m_cnt = 0;
                end else if (m_run) begin
                    m_cnt++;
                end
                if (m_run && m_delay >= 0 && m_cnt == m_delay) begin
                    spi_end_txn = 1'b1;
                    m_run       = 0;
                end else begin
                    spi_end_txn = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            if (clk_en) begin
                n_wr    += int'(spi_wr_en);
                n_start += int'(spi_start_txn);
                n_rd    += int'(spi_rd_en);
                n_rsp   += int'(rsp_valid != 4'b0);
                n_ready += int'(req_ready != 4'b0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_counts();
        n_wr = 0; n_start = 0; n_rd = 0; n_rsp = 0; n_ready = 0;
    endtask

    task automatic do_reset();
        sync_rst_n  = 1'b0;
        req_valid   = '0;
        m_run       = 0;
        repeat (3) @(negedge clk);
        sync_rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [1:0] peri,
                           input logic [1:0] mode, input logic [2:0] bytes,
                           input logic [63:0] wd);
        req_peri[i*2 +: 2]   = peri;
        req_mode[i*2 +: 2]   = mode;
        req_bytes[i*3 +: 3]  = bytes;
        req_wdata[i*64 +: 64] = wd;
        req_valid[i]         = 1'b1;
    endtask

    task automatic wait_ready(output int g, output bit ok, input bit drop);
        ok = 0;
        g  = -1;
        for (int c = 0; c < 300 && !ok; c++) begin
            @(negedge clk);
            if (req_ready != 4'b0) begin
                ok = 1;
                for (int i = 0; i < 4; i++) if (req_ready[i]) g = i;
                if (drop && g >= 0) req_valid[g] = 1'b0;
            end
        end
    endtask

    task automatic wait_rsp(output bit ok, output logic [63:0] rd,
                            output logic to, output logic [3:0] rv,
                            output logic [3:0] cs, output logic [63:0] wd);
        ok = 0; rd = '0; to = 1'b0; rv = '0; cs = '0; wd = '0;
        for (int c = 0; c < 300 && !ok; c++) begin
            @(negedge clk);
            if (rsp_valid != 4'b0) begin
                ok = 1;
                rd = rsp_rdata;
                to = rsp_timeout;
                rv = rsp_valid;
                cs = spi_chip_sel_one_cold;
                wd = spi_wr_data;
            end
        end
        for (int c = 0; c < 20 && rsp_valid != 4'b0; c++) @(negedge clk);
    endtask

    task automatic test_reset();
        sync_rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({req_ready, rsp_valid, rsp_timeout, spi_wr_en, spi_start_txn, spi_rd_en} !== 12'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 0",
                     {req_ready, rsp_valid, rsp_timeout, spi_wr_en, spi_start_txn, spi_rd_en});
        end
        n_tests++;
        if (spi_chip_sel_one_cold !== 4'hF) begin
            n_fail++;
            $display("FAIL reset_cs: got %b want 1111", spi_chip_sel_one_cold);
        end
        n_tests++;
        if ({spi_mode, spi_byte_sel, spi_wr_data, rsp_rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %h/%h/%h/%h want 0",
                     spi_mode, spi_byte_sel, spi_wr_data, rsp_rdata);
        end
        sync_rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if (spi_chip_sel_one_cold !== 4'hF || rsp_valid !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got cs=%b rv=%b want 1111/0000",
                     spi_chip_sel_one_cold, rsp_valid);
        end
    endtask

    task automatic test_single(input int mode);
        int g; bit ok; logic [63:0] rd, wd; logic to; logic [3:0] rv, cs;
        string nm;
        nm = (mode == 1) ? "clk_en" : "single";
        do_reset();
        en_mode = mode;
        repeat (2) @(negedge clk);
        clear_counts();
        m_delay     = 10;
        spi_rd_data = 64'h5A;
        set_req(0, 2'd2, 2'b01, 3'd0, 64'hA5);
        wait_ready(g, ok, 1);
        n_tests++;
        if (!ok || g != 0) begin
            n_fail++;
            $display("FAIL %s_grant: got ok=%0d g=%0d want 1/0", nm, ok, g);
        end
        wait_rsp(ok, rd, to, rv, cs, wd);
        n_tests++;
        if (!ok || rv !== 4'b0001) begin
            n_fail++;
            $display("FAIL %s_rsp_valid: got ok=%0d rv=%b want 1/0001", nm, ok, rv);
        end
        n_tests++;
        if (rd !== 64'h5A || to !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_rdata: got %h to=%b want 5a to=0", nm, rd, to);
        end
        n_tests++;
        if (cs !== 4'b1011 || wd !== 64'hA5) begin
            n_fail++;
            $display("FAIL %s_cs_wdata: got %b %h want 1011 a5", nm, cs, wd);
        end
        n_tests++;
        if (spi_mode !== 2'b01 || spi_byte_sel !== 3'd0) begin
            n_fail++;
            $display("FAIL %s_mode_bytes: got %b %0d want 01 0", nm, spi_mode, spi_byte_sel);
        end
        n_tests++;
        if (n_wr != 1 || n_start != 1 || n_rd != 1 || n_rsp != 1 || n_ready != 1) begin
            n_fail++;
            $display("FAIL %s_pulses: got wr=%0d st=%0d rd=%0d rsp=%0d rdy=%0d want all 1",
                     nm, n_wr, n_start, n_rd, n_rsp, n_ready);
        end
        n_tests++;
        if (spi_chip_sel_one_cold !== 4'hF) begin
            n_fail++;
            $display("FAIL %s_cs_release: got %b want 1111", nm, spi_chip_sel_one_cold);
        end
        en_mode = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_round_robin();
        int g; bit ok; logic [63:0] rd, wd; logic to; logic [3:0] rv, cs;
        int exp_g[5] = '{0, 1, 2, 3, 0};
        do_reset();
        m_delay     = 2;
        spi_rd_data = 64'h77;
        for (int i = 0; i < 4; i++) set_req(i, 2'(i), 2'b00, 3'd7, 64'(i));
        for (int k = 0; k < 5; k++) begin
            wait_ready(g, ok, 0);
            if (k == 4) req_valid = '0;
            n_tests++;
            if (!ok || g != exp_g[k]) begin
                n_fail++;
                $display("FAIL rr_grant%0d: got ok=%0d g=%0d want %0d", k, ok, g, exp_g[k]);
            end
            wait_rsp(ok, rd, to, rv, cs, wd);
            n_tests++;
            if (!ok || rv !== (4'b0001 << exp_g[k])) begin
                n_fail++;
                $display("FAIL rr_rsp%0d: got %b want %b", k, rv, 4'b0001 << exp_g[k]);
            end
        end
    endtask

    task automatic test_timeout();
        int g; bit ok; logic [63:0] rd, wd; logic to; logic [3:0] rv, cs;
        do_reset();
        m_delay     = -1;
        spi_rd_data = 64'hFFFF;
        set_req(1, 2'd0, 2'b10, 3'd3, 64'h1111);
        wait_ready(g, ok, 1);
        wait_rsp(ok, rd, to, rv, cs, wd);
        n_tests++;
        if (!ok || rv !== 4'b0010 || to !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_rsp: got ok=%0d rv=%b to=%b want 1/0010/1", ok, rv, to);
        end
        n_tests++;
        if (rd !== 64'h0 || cs !== 4'b1110) begin
            n_fail++;
            $display("FAIL timeout_data: got rd=%h cs=%b want 0/1110", rd, cs);
        end
        n_tests++;
        if (spi_chip_sel_one_cold !== 4'hF) begin
            n_fail++;
            $display("FAIL timeout_cs_release: got %b want 1111", spi_chip_sel_one_cold);
        end
        m_run = 0;
    endtask

    task automatic test_end_vs_timeout();
        int g; bit ok; logic [63:0] rd, wd; logic to; logic [3:0] rv, cs;
        do_reset();
        m_delay     = 15;
        spi_rd_data = 64'hDEAD_BEEF_0123_4567;
        set_req(0, 2'd3, 2'b11, 3'd7, 64'h2222);
        wait_ready(g, ok, 1);
        wait_rsp(ok, rd, to, rv, cs, wd);
        n_tests++;
        if (!ok || to !== 1'b0 || rv !== 4'b0001) begin
            n_fail++;
            $display("FAIL end_vs_to_flag: got ok=%0d to=%b rv=%b want 1/0/0001", ok, to, rv);
        end
        n_tests++;
        if (rd !== 64'hDEAD_BEEF_0123_4567 || cs !== 4'b0111) begin
            n_fail++;
            $display("FAIL end_vs_to_data: got %h cs=%b want deadbeef01234567/0111", rd, cs);
        end
    endtask

    task automatic test_reset_mid_busy();
        int g; bit ok; logic [63:0] rd, wd; logic to; logic [3:0] rv, cs;
        do_reset();
        m_delay = -1;
        set_req(2, 2'd2, 2'b01, 3'd1, 64'h3333);
        wait_ready(g, ok, 1);
        repeat (5) @(negedge clk);
        n_tests++;
        if (spi_chip_sel_one_cold !== 4'b1011) begin
            n_fail++;
            $display("FAIL midrst_busy_cs: got %b want 1011", spi_chip_sel_one_cold);
        end
        clear_counts();
        sync_rst_n = 1'b0;
        m_run      = 0;
        @(posedge clk);
        #1;
        n_tests++;
        if (spi_chip_sel_one_cold !== 4'hF || rsp_valid !== 4'b0 || spi_wr_data !== 64'h0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got cs=%b rv=%b wd=%h want 1111/0000/0",
                     spi_chip_sel_one_cold, rsp_valid, spi_wr_data);
        end
        @(negedge clk);
        sync_rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_tests++;
        if (n_rsp != 0) begin
            n_fail++;
            $display("FAIL midrst_no_rsp: got %0d rsp want 0", n_rsp);
        end
        m_delay     = 3;
        spi_rd_data = 64'h1234;
        set_req(3, 2'd1, 2'b00, 3'd2, 64'h4444);
        wait_ready(g, ok, 1);
        wait_rsp(ok, rd, to, rv, cs, wd);
        n_tests++;
        if (!ok || rv !== 4'b1000 || rd !== 64'h1234 || cs !== 4'b1101) begin
            n_fail++;
            $display("FAIL midrst_after: got rv=%b rd=%h cs=%b want 1000/1234/1101", rv, rd, cs);
        end
    endtask

    task automatic test_dropped_request();
        en_mode = 2;
        repeat (2) @(negedge clk);
        clear_counts();
        req_valid[2] = 1'b1;
        @(negedge clk);
        req_valid[2] = 1'b0;
        en_mode      = 0;
        repeat (10) @(negedge clk);
        n_tests++;
        if (n_ready != 0 || n_wr != 0) begin
            n_fail++;
            $display("FAIL dropped_req: got ready=%0d wr=%0d want 0/0", n_ready, n_wr);
        end
    endtask

    initial begin
        sync_rst_n  = 1'b0;
        req_valid   = '0;
        req_peri    = '0;
        req_mode    = '0;
        req_bytes   = '0;
        req_wdata   = '0;
        spi_rd_data = '0;
        clear_counts();
        test_reset();
        test_single(0);
        test_single(1);
        test_round_robin();
        test_timeout();
        test_end_vs_timeout();
        test_reset_mid_busy();
        test_dropped_request();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
